// File: rtl/netdma_irq_ctrl.sv
// Per-channel completion status and interrupt coalescing for netdma.
// One Avalon-MM CSR slave exposes global control, pending summary and a 4-word bank per channel.
module netdma_irq_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int SEQ_W      = 8,
    parameter int CSR_ADDR_W = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CSR_ADDR_W-1:0]     csr_address_i,
    input  logic                      csr_write_i,
    input  logic [31:0]               csr_writedata_i,
    input  logic                      csr_read_i,
    output logic [31:0]               csr_readdata_o,
    input  logic [CHANNELS-1:0]       done_i,
    input  logic [CHANNELS-1:0]       done_error_i,
    input  logic [CHANNELS-1:0]       done_disable_irq_i,
    input  logic [CHANNELS*SEQ_W-1:0] done_seq_i,
    output logic                      soft_reset_o,
    output logic                      irq_o
);
    localparam int WSEL_W = CSR_ADDR_W - 2;

    logic [WSEL_W-1:0] word_sel;
    logic [1:0]        word_k;
    logic              wr_glb;
    logic              unused_wdata;

    assign word_sel     = csr_address_i[CSR_ADDR_W-1:2];
    assign word_k       = csr_address_i[1:0];
    assign wr_glb       = csr_write_i && (csr_address_i == '0);
    assign unused_wdata = ^csr_writedata_i[31:16];

    logic                global_en_q, global_en_d;
    logic                soft_reset_q, soft_reset_d;
    logic                irq_q, irq_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [CHANNELS-1:0] irq_en_q, irq_en_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] error_q, error_d;
    logic [7:0]          thr_q [CHANNELS];
    logic [7:0]          thr_d [CHANNELS];
    logic [15:0]         tmo_q [CHANNELS];
    logic [15:0]         tmo_d [CHANNELS];
    logic [15:0]         timer_q [CHANNELS];
    logic [15:0]         timer_d [CHANNELS];
    logic [7:0]          count_q [CHANNELS];
    logic [7:0]          count_d [CHANNELS];
    logic [SEQ_W-1:0]    seq_q [CHANNELS];
    logic [SEQ_W-1:0]    seq_d [CHANNELS];

    always_comb begin : next_state
        logic        sel_ch;
        logic [16:0] tnext;
        logic [7:0]  thr_eff;
        global_en_d  = global_en_q;
        soft_reset_d = wr_glb && csr_writedata_i[0];
        irq_en_d     = irq_en_q;
        pending_d    = pending_q;
        error_d      = error_q;
        thr_d        = thr_q;
        tmo_d        = tmo_q;
        timer_d      = timer_q;
        count_d      = count_q;
        seq_d        = seq_q;
        sel_ch       = 1'b0;
        tnext        = '0;
        thr_eff      = 8'd1;
        if (wr_glb) begin
            global_en_d = csr_writedata_i[1];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            sel_ch = csr_write_i && (word_sel == WSEL_W'(c + 1));
            if (sel_ch && word_k == 2'd0) begin
                irq_en_d[c] = csr_writedata_i[0];
                thr_d[c]    = csr_writedata_i[15:8];
            end
            if (sel_ch && word_k == 2'd1) begin
                tmo_d[c] = csr_writedata_i[15:0];
            end
            if (soft_reset_q) begin
                pending_d[c] = 1'b0;
                error_d[c]   = 1'b0;
                seq_d[c]     = '0;
                count_d[c]   = '0;
                timer_d[c]   = '0;
            end else begin
                // Idle timer: evaluated on the old state, then W1C, then the new event.
                tnext = {1'b0, timer_q[c]} + 17'd1;
                if (count_q[c] != 8'd0 && !pending_q[c] && tmo_q[c] != 16'd0) begin
                    if (tnext >= {1'b0, tmo_q[c]}) begin
                        pending_d[c] = 1'b1;
                        timer_d[c]   = '0;
                    end else begin
                        timer_d[c] = tnext[15:0];
                    end
                end else begin
                    timer_d[c] = '0;
                end
                if (sel_ch && word_k == 2'd2) begin
                    if (csr_writedata_i[0]) begin
                        pending_d[c] = 1'b0;
                        count_d[c]   = '0;
                        timer_d[c]   = '0;
                    end
                    if (csr_writedata_i[1]) begin
                        error_d[c] = 1'b0;
                    end
                end
                if (done_i[c]) begin
                    seq_d[c] = done_seq_i[c*SEQ_W +: SEQ_W];
                    if (done_error_i[c]) begin
                        error_d[c] = 1'b1;
                    end
                    if (!done_disable_irq_i[c]) begin
                        if (count_d[c] != 8'hFF) begin
                            count_d[c] = count_d[c] + 8'd1;
                        end
                        thr_eff = (thr_q[c] == 8'd0) ? 8'd1 : thr_q[c];
                        if (count_d[c] >= thr_eff) begin
                            pending_d[c] = 1'b1;
                        end
                    end
                end
                if (pending_d[c]) begin
                    timer_d[c] = '0;
                end
            end
        end
        irq_d = global_en_q && |(pending_q & irq_en_q);
    end

    always_comb begin : read_mux
        rdata_d = rdata_q;
        if (csr_read_i) begin
            rdata_d = '0;
            if (csr_address_i == '0) begin
                rdata_d = {30'b0, global_en_q, 1'b0};
            end else if (csr_address_i == CSR_ADDR_W'(1)) begin
                rdata_d = 32'(pending_q);
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (word_sel == WSEL_W'(c + 1)) begin
                    case (word_k)
                        2'd0:    rdata_d = {16'b0, thr_q[c], 7'b0, irq_en_q[c]};
                        2'd1:    rdata_d = {16'b0, tmo_q[c]};
                        2'd2:    rdata_d = {8'b0, count_q[c], 8'(seq_q[c]), 6'b0, error_q[c], pending_q[c]};
                        default: rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            global_en_q  <= 1'b0;
            soft_reset_q <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
            irq_en_q     <= '0;
            pending_q    <= '0;
            error_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                thr_q[c]   <= '0;
                tmo_q[c]   <= '0;
                timer_q[c] <= '0;
                count_q[c] <= '0;
                seq_q[c]   <= '0;
            end
        end else begin
            global_en_q  <= global_en_d;
            soft_reset_q <= soft_reset_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
            irq_en_q     <= irq_en_d;
            pending_q    <= pending_d;
            error_q      <= error_d;
            thr_q        <= thr_d;
            tmo_q        <= tmo_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
        end
    end

    assign csr_readdata_o = rdata_q;
    assign soft_reset_o   = soft_reset_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_netdma_irq_ctrl.sv
// Directed bench for netdma_irq_ctrl: CSR access, coalescing, timeout, W1C races, saturation, soft reset.
module tb_netdma_irq_ctrl;
    localparam int CH = 2;
    localparam int SW = 8;
    localparam int AW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [AW-1:0]  csr_address = '0;
    logic           csr_write = 1'b0;
    logic [31:0]    csr_writedata = '0;
    logic           csr_read = 1'b0;
    logic [31:0]    csr_readdata;
    logic [CH-1:0]  done = '0;
    logic [CH-1:0]  done_error = '0;
    logic [CH-1:0]  done_disable = '0;
    logic [CH*SW-1:0] done_seq = '0;
    logic           soft_reset;
    logic           irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    netdma_irq_ctrl #(.CHANNELS(CH), .SEQ_W(SW), .CSR_ADDR_W(AW)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .csr_address_i      (csr_address),
        .csr_write_i        (csr_write),
        .csr_writedata_i    (csr_writedata),
        .csr_read_i         (csr_read),
        .csr_readdata_o     (csr_readdata),
        .done_i             (done),
        .done_error_i       (done_error),
        .done_disable_irq_i (done_disable),
        .done_seq_i         (done_seq),
        .soft_reset_o       (soft_reset),
        .irq_o              (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic pulse(input int ch, input logic [7:0] seq, input logic err, input logic dis);
        done = '0; done_error = '0; done_disable = '0; done_seq = '0;
        done[ch] = 1'b1; done_error[ch] = err; done_disable[ch] = dis;
        done_seq[ch*SW +: SW] = seq;
        @(negedge clk);
        done = '0; done_error = '0; done_disable = '0;
    endtask

    initial begin
        // Reset and empty register map
        cyc(3);
        rst = 1'b0;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_soft", 32'(soft_reset), 32'd0);
        check("reset_rdata", csr_readdata, 32'd0);
        for (int a = 0; a < 4 * (CH + 1) + 4; a++) begin
            rd(AW'(a), rv);
            check($sformatf("reset_rd_%0d", a), rv, 32'd0);
        end

        // Threshold coalescing on ch0
        wr(6'd0, 32'h2);
        wr(6'd4, 32'h0301);
        pulse(0, 8'd5, 1'b0, 1'b0);
        pulse(0, 8'd6, 1'b0, 1'b0);
        rd(6'd6, rv);
        check("ch0_two_events", rv, 32'h0002_0600);
        pulse(0, 8'd7, 1'b0, 1'b0);
        check("ch0_irq_lag", 32'(irq), 32'd0);
        cyc(1);
        check("ch0_irq_high", 32'(irq), 32'd1);
        rd(6'd6, rv);
        check("ch0_status", rv, 32'h0003_0701);
        rd(6'd1, rv);
        check("pending_summary", rv, 32'h1);
        wr(6'd6, 32'h1);
        check("ch0_w1c_irq_hold", 32'(irq), 32'd1);
        cyc(1);
        check("ch0_w1c_irq_drop", 32'(irq), 32'd0);
        rd(6'd6, rv);
        check("ch0_after_w1c", rv, 32'h0000_0700);

        // Idle timeout on ch1
        wr(6'd8, 32'h0A01);
        wr(6'd9, 32'd20);
        pulse(1, 8'h11, 1'b0, 1'b0);
        cyc(18);
        rd(6'd10, rv);
        check("ch1_before_timeout", rv, 32'h0001_1100);
        cyc(1);
        check("ch1_irq_not_yet", 32'(irq), 32'd0);
        rd(6'd10, rv);
        check("ch1_timeout_pending", rv, 32'h0001_1101);
        check("ch1_timeout_irq", 32'(irq), 32'd1);
        wr(6'd10, 32'h1);
        check("ch1_w1c_irq_hold", 32'(irq), 32'd1);
        cyc(1);
        check("ch1_w1c_irq_drop", 32'(irq), 32'd0);
        rd(6'd10, rv);
        check("ch1_after_w1c", rv, 32'h0000_1100);

        // W1C racing a counted done, threshold 1
        wr(6'd8, 32'h0101);
        pulse(1, 8'h22, 1'b0, 1'b0);
        csr_address = 6'd10; csr_writedata = 32'h1; csr_write = 1'b1;
        done = 2'b10; done_seq = {8'h23, 8'h00};
        @(negedge clk);
        csr_write = 1'b0; done = '0;
        rd(6'd10, rv);
        check("race_pending", rv, 32'h0001_2301);
        csr_address = 6'd10; csr_writedata = 32'h3; csr_write = 1'b1;
        done = 2'b10; done_error = 2'b10; done_seq = {8'h24, 8'h00};
        @(negedge clk);
        csr_write = 1'b0; done = '0; done_error = '0;
        rd(6'd10, rv);
        check("race_error", rv, 32'h0001_2403);
        wr(6'd10, 32'h3);
        rd(6'd10, rv);
        check("ch1_cleared", rv, 32'h0000_2400);

        // Non-counting erroneous completion
        pulse(0, 8'h55, 1'b1, 1'b1);
        rd(6'd6, rv);
        check("disable_irq_status", rv, 32'h0000_5502);
        cyc(1);
        check("disable_irq_irq", 32'(irq), 32'd0);

        // Count saturation, then soft reset
        wr(6'd4, 32'hFF01);
        for (int i = 0; i < 300; i++) pulse(0, 8'(i), 1'b0, 1'b0);
        rd(6'd6, rv);
        check("sat_status", rv, 32'h00FF_2B03);
        check("sat_irq", 32'(irq), 32'd1);
        wr(6'd0, 32'h3);
        check("soft_pulse_high", 32'(soft_reset), 32'd1);
        cyc(1);
        check("soft_pulse_low", 32'(soft_reset), 32'd0);
        rd(6'd6, rv);
        check("soft_status", rv, 32'h0);
        check("soft_irq", 32'(irq), 32'd0);
        rd(6'd4, rv);
        check("soft_ctrl_kept", rv, 32'h0000_FF01);
        rd(6'd0, rv);
        check("soft_global_kept", rv, 32'h2);
        rd(6'd9, rv);
        check("soft_timeout_kept", rv, 32'd20);

        // Unmapped addresses
        wr(6'd12, 32'hFFFF);
        rd(6'd12, rv);
        check("unmapped_rd", rv, 32'h0);
        rd(6'd3, rv);
        check("reserved_rd", rv, 32'h0);

        // Hard reset mid soft-reset pulse
        wr(6'd0, 32'h3);
        rst = 1'b1;
        #1;
        check("rst_kills_soft", 32'(soft_reset), 32'd0);
        check("rst_rdata", csr_readdata, 32'd0);
        cyc(2);
        rst = 1'b0;
        rd(6'd0, rv);
        check("rst_global", rv, 32'h0);
        rd(6'd4, rv);
        check("rst_ctrl", rv, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/netdma_irq_ctrl.md
# netdma_irq_ctrl

Parametrised N-channel interrupt and status controller for netdma. It replaces the fixed rx/tx control/status register pair with a per-channel register bank behind one Avalon-MM CSR slave. It collects completion events from the read/write masters and records the last sequence number and error flags per channel. Interrupts are coalesced by an event-count threshold and an idle timeout, and the result drives a single level interrupt towards the host.

## Interface
Parameters:
- CHANNELS, 2: number of DMA channels, 1..15.
- SEQ_W, 8: sequence number width, ≤ 8.
- CSR_ADDR_W, 6: CSR word address width; must satisfy 4*(CHANNELS+1) ≤ 2^CSR_ADDR_W.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: asynchronous, active-high reset.
- csr_address_i, in, CSR_ADDR_W: word address.
- csr_write_i, in, 1: write strobe.
- csr_writedata_i, in, 32: write data.
- csr_read_i, in, 1: read strobe.
- csr_readdata_o, out, 32: read data, registered.
- done_i, in, CHANNELS: one-cycle completion pulse per channel.
- done_error_i, in, CHANNELS: completion had an error; qualified by done_i.
- done_disable_irq_i, in, CHANNELS: completion must not count towards interrupts.
- done_seq_i, in, CHANNELS*SEQ_W: sequence number of the completion; channel c occupies bits [c*SEQ_W +: SEQ_W].
- soft_reset_o, out, 1: one-cycle pulse on software reset.
- irq_o, out, 1: level interrupt, registered.

## Operation
Register map, by word address:
- 0, global control: bit0 soft reset (write 1 only, reads 0); bit1 global irq enable (R/W).
- 1, pending summary (RO): bits [CHANNELS-1:0] hold the per-channel pending flags.
- 2..3: read 0, writes ignored.
- Channel c occupies addresses 4(c+1)+k:
  - k=0, ctrl: bit0 irq_en; [15:8] threshold.
  - k=1, timeout [15:0], in clk_i cycles; 0 disables the timeout.
  - k=2, status: bit0 pending (W1C); bit1 error (W1C); [15:8] last_seq (zero-extended); [23:16] count (RO).
  - k=3: reads 0.
- Addresses beyond the last channel read 0 and ignore writes.

Per-channel behaviour, on each done_i[c]:
- last_seq is loaded from done_seq_i.
- error is set if done_error_i[c] is high. It is sticky and is cleared only by W1C.
- If done_disable_irq_i[c] is high, the event stops here: count, timer and pending are unchanged.
- Otherwise count increments, saturating at 255. pending sets when the new count ≥ threshold; a threshold of 0 is treated as 1.

Per-channel timer:
- Runs while count>0, pending=0 and timeout≠0, incrementing by 1 per cycle.
- When the timer reaches timeout, pending sets and the timer clears.
- The timer is held at 0 whenever count=0 or pending=1.

Clearing pending:
- A W1C of pending clears pending, count and timer.
- If done_i arrives in the same cycle, the clear applies first, then the event: count=1, and pending is re-evaluated against threshold.
- A W1C of error with a simultaneous erroneous done leaves error at 1.

Interrupt output: irq_o = global_en AND OR over c of (pending[c] AND irq_en[c]). Clearing irq_en masks the interrupt but leaves pending untouched.

Soft reset (write 1 to address 0 bit0):
- soft_reset_o pulses high for one cycle.
- All per-channel status and counters (pending, error, last_seq, count, timer) clear on the following edge.
- ctrl, timeout and global_en are kept.

## Timing
- Reset values: csr_readdata_o=0, irq_o=0, soft_reset_o=0; all registers 0, so threshold 0 acts as 1.
- Read latency is 1 cycle: csr_readdata_o is valid on the cycle after csr_read_i and holds until the next read. The value returned reflects state before any same-cycle write.
- A write takes effect on the clock edge on which csr_write_i is sampled.
- A done_i sampled at edge N makes pending visible in status at N+1 and raises irq_o at N+2.
- Timeout: with timeout=T, the timer starts on the cycle after the first counted event, and pending sets T cycles after that event.
- Simultaneous read and write are both honoured.
- Asserting rst_i mid-operation clears everything immediately, including an in-flight soft_reset_o.

## Test plan
- Reset, then read addresses 0..4(CHANNELS+1)+3 -> all read 0; irq_o=0.
- global_en=1, ch0 irq_en=1, threshold=3, timeout=0; send 3 done pulses with seq 5,6,7 -> pending sets on the third pulse only; irq_o rises 2 cycles later; status reads 0x0003_0701.
- ch1 threshold=10, timeout=20; 1 done pulse -> pending=1 exactly 20 cycles after the pulse; W1C of pending -> count=0 and irq_o drops 1 cycle later.
- W1C of pending in the same cycle as a counted done with threshold=1 -> pending stays 1 and count=1.
- done with done_disable_irq_i=1 and done_error_i=1 -> error=1 and last_seq updated; count=0, pending=0, irq_o=0.
- 300 counted dones with threshold=255 -> count saturates at 255 and pending=1. A soft reset then pulses soft_reset_o for 1 cycle, and status reads 0 while ctrl is preserved.
